// File: rtl/opr1_incr_rotate_pkg.sv
// Shared types and constants for the Operate Group 1 increment/rotate back half.
package opr1_incr_rotate_pkg;

    localparam int WORD_W = 12;
    localparam logic [WORD_W-1:0] AC_RESET = 12'o0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INC,
        ST_ROT1,
        ST_ROT2,
        ST_FIN
    } state_e;

    typedef enum logic [1:0] {
        ROT_NONE,
        ROT_LEFT,
        ROT_RIGHT,
        ROT_BSW
    } rot_op_e;

endpackage

// File: rtl/opr1_incr_rotate_link_ac_rotate.sv
// Combinational rotate/byte-swap of the {L,AC} pair; one step per use.
module link_ac_rotate
    import opr1_incr_rotate_pkg::*;
(
    input  logic              link_in,
    input  logic [WORD_W-1:0] ac_in,
    input  rot_op_e           rot_op,
    output logic              link_out,
    output logic [WORD_W-1:0] ac_out
);

    always_comb begin
        link_out = link_in;
        ac_out   = ac_in;
        case (rot_op)
            ROT_LEFT:  {link_out, ac_out} = {ac_in, link_in};
            ROT_RIGHT: {link_out, ac_out} = {ac_in[0], link_in, ac_in[WORD_W-1:1]};
            // Byte swap exchanges the 6-bit halves of AC and leaves the link alone.
            ROT_BSW:   ac_out = {ac_in[5:0], ac_in[WORD_W-1:6]};
            default: ;
        endcase
    end

endmodule

// File: rtl/opr1_incr_rotate.sv
// Sequential IAC then RAL/RAR/RTL/RTR/BSW on {L,AC}, one micro-op per clock.
// Define OPR1_BSW_EN to enable BSW (RAL=RAR=0, TWICE=1); otherwise that case is a no-op.
module opr1_incr_rotate
    import opr1_incr_rotate_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              START,
    input  logic [WORD_W-1:0] AC_IN,
    input  logic              L_IN,
    input  logic              IAC,
    input  logic              RAL,
    input  logic              RAR,
    input  logic              TWICE,
    output logic [WORD_W-1:0] AC_OUT,
    output logic              L_OUT,
    output logic              BUSY,
    output logic              DONE
);

`ifdef OPR1_BSW_EN
    localparam bit BSW_EN = 1'b1;
`else
    localparam bit BSW_EN = 1'b0;
`endif

    function automatic rot_op_e decode_rot(input logic ral, input logic rar, input logic twice);
        if (ral && !rar)                       return ROT_LEFT;
        else if (rar && !ral)                  return ROT_RIGHT;
        else if (BSW_EN && !ral && !rar && twice) return ROT_BSW;
        else                                   return ROT_NONE;
    endfunction

    state_e            state_q, state_d;
    logic [WORD_W-1:0] ac_q, ac_d;
    logic              l_q, l_d;
    logic              ral_q, ral_d, rar_q, rar_d, twice_q, twice_d;
    logic              busy_q, busy_d, done_q, done_d;

    rot_op_e           rot_op, cap_op;
    logic              rot_l;
    logic [WORD_W-1:0] rot_ac;
    logic [WORD_W:0]   inc_sum;

    assign rot_op  = decode_rot(ral_q, rar_q, twice_q);
    assign cap_op  = decode_rot(RAL, RAR, TWICE);
    assign inc_sum = {l_q, ac_q} + 13'd1;

    link_ac_rotate u_rot (
        .link_in  (l_q),
        .ac_in    (ac_q),
        .rot_op   (rot_op),
        .link_out (rot_l),
        .ac_out   (rot_ac)
    );

    // DONE/BUSY are registered, so the DONE cycle is observed while the state is
    // already IDLE; a START during that cycle is still treated as outside IDLE.
    always_comb begin
        state_d = state_q;
        ac_d    = ac_q;
        l_d     = l_q;
        ral_d   = ral_q;
        rar_d   = rar_q;
        twice_d = twice_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START && !done_q) begin
                    ac_d    = AC_IN;
                    l_d     = L_IN;
                    ral_d   = RAL;
                    rar_d   = RAR;
                    twice_d = TWICE;
                    busy_d  = 1'b1;
                    if (IAC)                   state_d = ST_INC;
                    else if (cap_op != ROT_NONE) state_d = ST_ROT1;
                    else                       state_d = ST_FIN;
                end
            end
            ST_INC: begin
                {l_d, ac_d} = inc_sum;
                busy_d      = 1'b1;
                state_d     = (rot_op != ROT_NONE) ? ST_ROT1 : ST_FIN;
            end
            ST_ROT1: begin
                l_d     = rot_l;
                ac_d    = rot_ac;
                busy_d  = 1'b1;
                state_d = (twice_q && (rot_op == ROT_LEFT || rot_op == ROT_RIGHT)) ? ST_ROT2 : ST_FIN;
            end
            ST_ROT2: begin
                l_d     = rot_l;
                ac_d    = rot_ac;
                busy_d  = 1'b1;
                state_d = ST_FIN;
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ac_q    <= AC_RESET;
            l_q     <= 1'b0;
            ral_q   <= 1'b0;
            rar_q   <= 1'b0;
            twice_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ac_q    <= ac_d;
            l_q     <= l_d;
            ral_q   <= ral_d;
            rar_q   <= rar_d;
            twice_q <= twice_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign AC_OUT = ac_q;
    assign L_OUT  = l_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_opr1_incr_rotate.sv
// Directed bench for opr1_incr_rotate: values, DONE latency, BUSY length, reset abort.
module tb_opr1_incr_rotate;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        START = 1'b0;
    logic [11:0] AC_IN = 12'o0000;
    logic        L_IN = 1'b0;
    logic        IAC = 1'b0, RAL = 1'b0, RAR = 1'b0, TWICE = 1'b0;
    logic [11:0] AC_OUT;
    logic        L_OUT, BUSY, DONE;

    int n_checks = 0;
    int n_fail   = 0;

    opr1_incr_rotate dut (
        .clk    (clk),
        .reset  (reset),
        .START  (START),
        .AC_IN  (AC_IN),
        .L_IN   (L_IN),
        .IAC    (IAC),
        .RAL    (RAL),
        .RAR    (RAR),
        .TWICE  (TWICE),
        .AC_OUT (AC_OUT),
        .L_OUT  (L_OUT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    // Start one operation, scramble inputs after capture, and track DONE/BUSY.
    task automatic run_op(input string tag, input logic [11:0] ac, input logic l,
                          input logic iac, input logic ral, input logic rar, input logic twice,
                          input logic [11:0] exp_ac, input logic exp_l, input int exp_done,
                          input int mid_edge, input logic [11:0] mid_ac, input logic mid_l,
                          input logic poke);
        int edge_n, done_at, busy_cnt;
        @(negedge clk);
        AC_IN = ac; L_IN = l; IAC = iac; RAL = ral; RAR = rar; TWICE = twice; START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        AC_IN = ~ac; L_IN = ~l; IAC = ~iac; RAL = ~ral; RAR = rar; TWICE = ~twice;
        edge_n = 0; done_at = -1; busy_cnt = 0;
        if (BUSY) busy_cnt++;
        while (done_at < 0 && edge_n < 12) begin
            @(posedge clk); #1;
            edge_n++;
            START = poke && (edge_n == 1);
            if (edge_n == mid_edge) begin
                check({tag, "_mid_ac"}, int'(AC_OUT), int'(mid_ac));
                check({tag, "_mid_l"}, int'(L_OUT), int'(mid_l));
            end
            if (DONE) done_at = edge_n;
            else if (BUSY) busy_cnt++;
        end
        START = 1'b0;
        check({tag, "_done_edge"}, done_at, exp_done);
        check({tag, "_busy_cycles"}, busy_cnt, exp_done);
        check({tag, "_ac"}, int'(AC_OUT), int'(exp_ac));
        check({tag, "_l"}, int'(L_OUT), int'(exp_l));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, int'(DONE), 0);
        check({tag, "_idle_busy"}, int'(BUSY), 0);
        check({tag, "_hold_ac"}, int'(AC_OUT), int'(exp_ac));
    endtask

    initial begin
        int done_seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ac", int'(AC_OUT), 0);
        check("rst_l", int'(L_OUT), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("iac_wrap", 12'o7777, 1'b0, 1, 0, 0, 0, 12'o0000, 1'b1, 2, -1, 12'o0, 1'b0, 1'b0);
        run_op("ral", 12'o4000, 1'b0, 0, 1, 0, 0, 12'o0000, 1'b1, 2, -1, 12'o0, 1'b0, 1'b0);
        run_op("rtr", 12'o0001, 1'b0, 0, 0, 1, 1, 12'o4000, 1'b0, 3, 1, 12'o0000, 1'b1, 1'b0);
        run_op("iac_ral", 12'o3777, 1'b0, 1, 1, 0, 0, 12'o0000, 1'b1, 3, 1, 12'o4000, 1'b0, 1'b0);
        run_op("iac_rtl", 12'o1234, 1'b0, 1, 1, 0, 1, 12'o5164, 1'b0, 4, 1, 12'o1235, 1'b0, 1'b0);
        run_op("capture", 12'o1234, 1'b1, 0, 0, 0, 0, 12'o1234, 1'b1, 1, -1, 12'o0, 1'b0, 1'b0);
`ifdef OPR1_BSW_EN
        run_op("bsw", 12'o0077, 1'b1, 0, 0, 0, 1, 12'o7700, 1'b1, 2, -1, 12'o0, 1'b0, 1'b0);
`else
        run_op("bsw_off", 12'o0077, 1'b1, 0, 0, 0, 1, 12'o0077, 1'b1, 1, -1, 12'o0, 1'b0, 1'b0);
`endif
        run_op("both_rot", 12'o0005, 1'b1, 1, 1, 1, 1, 12'o0006, 1'b1, 2, -1, 12'o0, 1'b0, 1'b0);
        run_op("start_busy", 12'o1234, 1'b0, 1, 1, 0, 1, 12'o5164, 1'b0, 4, 1, 12'o1235, 1'b0, 1'b1);

        // Abort an IAC+RTL with reset sampled at edge 2.
        @(negedge clk);
        AC_IN = 12'o1234; L_IN = 1'b1; IAC = 1'b1; RAL = 1'b1; RAR = 1'b0; TWICE = 1'b1; START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ac", int'(AC_OUT), 0);
        check("abort_l", int'(L_OUT), 0);
        check("abort_busy", int'(BUSY), 0);
        check("abort_done", int'(DONE), 0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (DONE) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle_busy", int'(BUSY), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
